calc_seq_ctrl: RTL and testbench
================================

Name: calc_seq_ctrl

Overview:
- Sequencing controller for the calculator datapath, placed directly after the input buffer.
- Accepts a one-cycle start pulse with two latched unsigned operands and a 4-bit opcode.
- Dispatches single-cycle ops to a combinational ALU path, or multiply/divide/modulo to an iterative shift-add / restoring-divide unit.
- Returns a registered result with a one-cycle done pulse and status flags.

Parameters:
- WIDTH, 10, operand width; result width is 2*WIDTH; iteration count for MUL/DIV/MOD is WIDTH.

Ports:
- clock  input  1  system clock
- reset  input  1  reset, asynchronous, active-high
- num1  input  WIDTH  operand A, sampled only on an accepted start
- num2  input  WIDTH  operand B, sampled only on an accepted start
- op  input  4  opcode, sampled only on an accepted start
- start  input  1  one-cycle request pulse
- result  output  2*WIDTH  registered result, held until the next done
- done  output  1  one-cycle pulse; result and flags valid in the same cycle
- busy  output  1  high while an operation is in flight
- err  output  1  divide/modulo by zero or illegal opcode; updated with done
- neg  output  1  SUB borrow (num1 < num2); updated with done
- overrun  output  1  one-cycle pulse when start arrives while busy

Behaviour:
- Reset: asynchronous, active-high; clock is clock. All outputs clear to 0, state goes to IDLE, counter clears to 0. Reset mid-operation aborts the operation and produces no done.
- Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 AND, 6 OR, 7 XOR, 8 SHL, 9 SHR; 10-15 are illegal.
- States: IDLE, EXEC, ITER, FIN.
- IDLE: at an edge (E0) with start=1, latch num1/num2/op into a/b/opr and set busy<=1.
  - MUL, or DIV/MOD with b!=0: go to ITER, counter<=0.
  - All other ops: go to EXEC.
- EXEC: at the next edge (E1), write result and flags, done<=1, busy<=0, go to IDLE.
- ITER: one iteration per edge; counter increments; after WIDTH iterations go to FIN.
  - MUL is LSB-first shift-add.
  - DIV/MOD is restoring division, MSB-first.
- FIN: at the next edge, write result, done<=1, busy<=0, go to IDLE. Total latency from E0 to done is WIDTH+2 edges (E12 for WIDTH=10).
- done is deasserted on the edge after it is asserted. result, err and neg hold until the next done.
- Arithmetic (all unsigned, results zero-extended to 2*WIDTH):
  - ADD: a+b, WIDTH+1 bits.
  - SUB: (a-b) mod 2^WIDTH; neg=(a<b).
  - MUL: full 2*WIDTH product.
  - DIV: quotient.
  - MOD: remainder.
  - AND/OR/XOR: bitwise.
  - SHL: a<<b[3:0], 2*WIDTH bits wide.
  - SHR: a>>b[3:0].
  - neg=0 for every op except SUB.
- DIV/MOD with b=0: take the EXEC path; result=0, err=1.
- Illegal opcode: EXEC path; result=0, err=1. err=0 otherwise.
- start while busy=1, including in the FIN cycle: ignored, and overrun pulses on the next cycle. Operands are not disturbed.
- start in the same cycle done is high: accepted, because state is IDLE and busy=0. This gives back-to-back operation.
- Operand inputs changing while busy have no effect.

Decomposition:
- Shared package calc_pkg:
  - op_t enum with the opcodes above.
  - state_t enum: IDLE/EXEC/ITER/FIN.
  - Constants OPW=4 and default WIDTH=10.
  - is_iterative() function (MUL/DIV/MOD).
- Sub-module seq_muldiv:
  - Holds the iterative shift-add/restoring-divide datapath: accumulator, partial remainder, shifted operand.
  - Interface: load, step, mode (mul/div); outputs product, quotient, remainder.
  - calc_seq_ctrl owns the FSM, counter and single-cycle ALU.

Test Plan:
- ADD num1=1000 num2=1000, start at E0 → done at E1 only, result=2000 (0x007D0), err=0, neg=0, busy high for exactly one cycle.
- SUB 5-9 → result=0x3FC, neg=1. MUL 1023*1023 → result=1046529 (0xFF801), done exactly at E12, busy high for E0 through E12.
- DIV 1000/7 → result=142; MOD 1000%7 → result=6; both with done at E12. DIV 55/0 → result=0, err=1, done at E1.
- Start pulse at E5 during a MUL → overrun pulses one cycle, MUL result unchanged. op=12 → err=1, result=0.
- Back-to-back: a second start (ADD 3+4) in the done cycle of a DIV → accepted, result=7 at the following edge.
- Reset asserted mid-MUL (E6) → all outputs 0 immediately, no done; a subsequent ADD 1+1 gives result=2 normally.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and helpers for the calculator sequencing controller.
package calc_pkg;

  localparam int OPW       = 4;
  localparam int DEF_WIDTH = 10;

  typedef enum logic [OPW-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_MOD = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_XOR = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_ITER = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  // Ops that need the multi-cycle shift-add / restoring-divide unit.
  function automatic logic is_iterative(input logic [OPW-1:0] o);
    return (o == OP_MUL) || (o == OP_DIV) || (o == OP_MOD);
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative datapath: LSB-first shift-add multiply and MSB-first restoring
// divide. One step per asserted 'step'; 'load' captures fresh operands.
module seq_muldiv
  import calc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic                 mode_mul,
  input  logic [WIDTH-1:0]     opa,
  input  logic [WIDTH-1:0]     opb,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder
);

  localparam int RW = 2 * WIDTH;

  logic [RW-1:0]    acc;      // running product
  logic [RW-1:0]    mcand;    // multiplicand, shifted left each step
  logic [WIDTH-1:0] shreg;    // multiplier (mul) or dividend->quotient (div)
  logic [WIDTH-1:0] rem;      // partial remainder
  logic [WIDTH-1:0] divisor;
  logic             mul_mode;

  logic [WIDTH:0]   rem_sh;
  logic             fits;
  logic [WIDTH-1:0] rem_sub;

  // Restoring-divide trial: shift next dividend bit into the remainder and
  // compare against the divisor. When it fits the true difference is below
  // the divisor, so the low WIDTH bits of the subtraction are exact.
  always_comb begin
    rem_sh  = {rem, shreg[WIDTH-1]};
    fits    = (rem_sh >= {1'b0, divisor});
    rem_sub = rem_sh[WIDTH-1:0] - divisor;
  end

  // Operand capture on load, one multiply or divide iteration per step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      mcand    <= '0;
      shreg    <= '0;
      rem      <= '0;
      divisor  <= '0;
      mul_mode <= 1'b0;
    end else if (load) begin
      acc      <= '0;
      mcand    <= RW'(opa);
      shreg    <= mode_mul ? opb : opa;
      rem      <= '0;
      divisor  <= opb;
      mul_mode <= mode_mul;
    end else if (step) begin
      if (mul_mode) begin
        if (shreg[0]) acc <= acc + mcand;
        mcand <= mcand << 1;
        shreg <= shreg >> 1;
      end else if (fits) begin
        rem   <= rem_sub;
        shreg <= {shreg[WIDTH-2:0], 1'b1};
      end else begin
        rem   <= rem_sh[WIDTH-1:0];
        shreg <= {shreg[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign product   = acc;
  assign quotient  = shreg;
  assign remainder = rem;

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencing controller: accepts a start pulse, runs single-cycle
// ops through a combinational ALU or MUL/DIV/MOD through seq_muldiv, and
// returns a registered result with a one-cycle done pulse.
//
// Handshake: start is a request pulse honoured only when busy=0 (state IDLE,
// which includes the cycle where done=1). A start seen while busy=1 is
// dropped and flagged by a one-cycle overrun pulse on the following cycle.
// done is a one-cycle pulse; result/err/neg are valid with it and hold until
// the next done.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     num1,
  input  logic [WIDTH-1:0]     num2,
  input  logic [OPW-1:0]       op,
  input  logic                 start,
  output logic [2*WIDTH-1:0]   result,
  output logic                 done,
  output logic                 busy,
  output logic                 err,
  output logic                 neg,
  output logic                 overrun,
  output logic [1:0]           dbg_state
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OPW-1:0]   opr;
  logic [CW-1:0]    count;

  logic             go_iter;
  logic             md_load;
  logic             md_step;
  logic [RW-1:0]    md_product;
  logic [WIDTH-1:0] md_quotient;
  logic [WIDTH-1:0] md_remainder;
  logic [RW-1:0]    iter_res;

  logic [RW-1:0]    alu_res;
  logic             alu_err;
  logic             alu_neg;
  logic [WIDTH-1:0] diff;

  // Decide on the accepting edge whether the op uses the iterative unit;
  // divide by zero is diverted to the single-cycle error path.
  always_comb begin
    go_iter = is_iterative(op) && ((op == OP_MUL) || (num2 != '0));
    md_load = (state == S_IDLE) && start && go_iter;
    md_step = (state == S_ITER) && (count != LAST);
  end

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clock     (clock),
    .reset     (reset),
    .load      (md_load),
    .step      (md_step),
    .mode_mul  (op == OP_MUL),
    .opa       (num1),
    .opb       (num2),
    .product   (md_product),
    .quotient  (md_quotient),
    .remainder (md_remainder)
  );

  // Select the finished iterative result for the latched opcode.
  always_comb begin
    iter_res = md_product;
    if (opr == OP_DIV) iter_res = RW'(md_quotient);
    if (opr == OP_MOD) iter_res = RW'(md_remainder);
  end

  // Single-cycle ALU over the latched operands.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    alu_neg = 1'b0;
    diff    = a - b;
    case (opr)
      OP_ADD: alu_res = RW'(a) + RW'(b);
      OP_SUB: begin
        alu_res = RW'(diff);
        alu_neg = (a < b);
      end
      OP_DIV, OP_MOD: alu_err = 1'b1;  // only reach EXEC when b == 0
      OP_MUL: alu_res = '0;            // never executed here
      OP_AND: alu_res = RW'(a & b);
      OP_OR:  alu_res = RW'(a | b);
      OP_XOR: alu_res = RW'(a ^ b);
      OP_SHL: alu_res = RW'(a) << b[3:0];
      OP_SHR: alu_res = RW'(a >> b[3:0]);
      default: alu_err = 1'b1;
    endcase
  end

  // Control FSM with registered outputs and iteration counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      a       <= '0;
      b       <= '0;
      opr     <= '0;
      count   <= '0;
      result  <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      neg     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done    <= 1'b0;
      overrun <= start && busy;
      case (state)
        S_IDLE: begin
          if (start) begin
            a    <= num1;
            b    <= num2;
            opr  <= op;
            busy <= 1'b1;
            if (go_iter) begin
              state <= S_ITER;
              count <= '0;
            end else begin
              state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          result <= alu_res;
          err    <= alu_err;
          neg    <= alu_neg;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        S_ITER: begin
          if (count == LAST) state <= S_FIN;
          else               count <= count + 1'b1;
        end
        S_FIN: begin
          result <= iter_res;
          err    <= 1'b0;
          neg    <= 1'b0;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl: vector table plus multi-cycle sequences.
module tb_calc_seq_ctrl;

  localparam int W  = 10;
  localparam int RW = 2 * W;

  // clock / reset
  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  num1  = '0;
  logic [W-1:0]  num2  = '0;
  logic [3:0]    op    = '0;
  logic          start = 1'b0;
  logic [RW-1:0] result;
  logic          done, busy, err, neg, overrun;
  logic [1:0]    dbg_state;

  always #5 clock = ~clock;

  calc_seq_ctrl #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .num1      (num1),
    .num2      (num2),
    .op        (op),
    .start     (start),
    .result    (result),
    .done      (done),
    .busy      (busy),
    .err       (err),
    .neg       (neg),
    .overrun   (overrun),
    .dbg_state (dbg_state)
  );

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [RW-1:0] exp_q[$];

  typedef struct {
    logic [3:0]    op;
    logic [W-1:0]  n1;
    logic [W-1:0]  n2;
    logic [RW-1:0] res;
    logic          err;
    logic          neg;
    int            lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, expv);
    end
  endtask

  task automatic add_vec(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [RW-1:0] r, input logic e, input logic n, input int l);
    vec_t v;
    v.op = o; v.n1 = x; v.n2 = y; v.res = r; v.err = e; v.neg = n; v.lat = l;
    vecs.push_back(v);
  endtask

  // Wait for done, at most maxc edges; lat = edges waited (0 on timeout).
  task automatic wait_done(input int maxc, output int lat);
    int k;
    lat = 0;
    k = 0;
    while (lat == 0 && k < maxc) begin
      @(posedge clock); #1;
      k++;
      if (done) lat = k;
    end
  endtask

  // driver: issue one op at the next edge E0 and return after E0 + 1ns
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clock);
    num1 = x; num2 = y; op = o; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    num1 = W'($urandom_range(0, 1023));
    num2 = W'($urandom_range(0, 1023));
    op   = 4'($urandom_range(0, 15));
  endtask

  task automatic run_op(input string nm, input vec_t v);
    int lat;
    issue(v.op, v.n1, v.n2);
    exp_q.push_back(v.res);
    chk({nm, ".busy_e0"}, 32'(busy), 32'd1);
    wait_done(40, lat);
    if (lat == 0) begin
      chk({nm, ".timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end else begin
      chk({nm, ".lat"}, lat, v.lat);
      chk({nm, ".result"}, 32'(result), 32'(exp_q.pop_front()));
      chk({nm, ".err"}, 32'(err), 32'(v.err));
      chk({nm, ".neg"}, 32'(neg), 32'(v.neg));
      chk({nm, ".busy_done"}, 32'(busy), 32'd0);
      @(posedge clock); #1;
      chk({nm, ".done_drop"}, 32'(done), 32'd0);
      chk({nm, ".result_hold"}, 32'(result), 32'(v.res));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat;
    int stray;

    // 0 ADD 1 SUB 2 MUL 3 DIV 4 MOD 5 AND 6 OR 7 XOR 8 SHL 9 SHR
    add_vec(4'd0, 10'd1000, 10'd1000, 20'd2000,    1'b0, 1'b0, 1);
    add_vec(4'd0, 10'd1023, 10'd1023, 20'd2046,    1'b0, 1'b0, 1);
    add_vec(4'd1, 10'd5,    10'd9,    20'h003FC,   1'b0, 1'b1, 1);
    add_vec(4'd1, 10'd9,    10'd5,    20'd4,       1'b0, 1'b0, 1);
    add_vec(4'd1, 10'd7,    10'd7,    20'd0,       1'b0, 1'b0, 1);
    add_vec(4'd2, 10'd1023, 10'd1023, 20'hFF801,   1'b0, 1'b0, 12);
    add_vec(4'd2, 10'd0,    10'd5,    20'd0,       1'b0, 1'b0, 12);
    add_vec(4'd2, 10'd37,   10'd29,   20'd1073,    1'b0, 1'b0, 12);
    add_vec(4'd3, 10'd1000, 10'd7,    20'd142,     1'b0, 1'b0, 12);
    add_vec(4'd4, 10'd1000, 10'd7,    20'd6,       1'b0, 1'b0, 12);
    add_vec(4'd3, 10'd55,   10'd0,    20'd0,       1'b1, 1'b0, 1);
    add_vec(4'd4, 10'd9,    10'd0,    20'd0,       1'b1, 1'b0, 1);
    add_vec(4'd3, 10'd5,    10'd9,    20'd0,       1'b0, 1'b0, 12);
    add_vec(4'd4, 10'd5,    10'd9,    20'd5,       1'b0, 1'b0, 12);
    add_vec(4'd3, 10'd1023, 10'd1,    20'd1023,    1'b0, 1'b0, 12);
    add_vec(4'd4, 10'd1023, 10'd1023, 20'd0,       1'b0, 1'b0, 12);
    add_vec(4'd5, 10'h3F0,  10'h0FF,  20'h000F0,   1'b0, 1'b0, 1);
    add_vec(4'd6, 10'h300,  10'h00F,  20'h0030F,   1'b0, 1'b0, 1);
    add_vec(4'd7, 10'h3FF,  10'h155,  20'h002AA,   1'b0, 1'b0, 1);
    add_vec(4'd8, 10'h3FF,  10'd15,   20'hF8000,   1'b0, 1'b0, 1);
    add_vec(4'd8, 10'd5,    10'h3F3,  20'd40,      1'b0, 1'b0, 1);
    add_vec(4'd9, 10'h3FF,  10'd4,    20'h0003F,   1'b0, 1'b0, 1);
    add_vec(4'd9, 10'h200,  10'h3FA,  20'd0,       1'b0, 1'b0, 1);
    add_vec(4'd12, 10'd3,   10'd4,    20'd0,       1'b1, 1'b0, 1);
    add_vec(4'd15, 10'd3,   10'd4,    20'd0,       1'b1, 1'b0, 1);
    add_vec(4'd0, 10'd1,    10'd2,    20'd3,       1'b0, 1'b0, 1);

    // reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst.result", 32'(result), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.flags", 32'({err, neg, overrun}), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("idle.busy", 32'(busy), 32'd0);
    chk("idle.done", 32'(done), 32'd0);

    // vector table
    for (int i = 0; i < vecs.size(); i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // overrun at E5 during MUL, and start in the FIN cycle
    issue(4'd2, 10'd1023, 10'd1023);
    exp_q.push_back(20'hFF801);
    repeat (4) @(posedge clock);
    @(negedge clock);
    num1 = 10'd3; num2 = 10'd4; op = 4'd0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("ovr.pulse_e5", 32'(overrun), 32'd1);
    chk("ovr.busy_e5", 32'(busy), 32'd1);
    @(posedge clock); #1;
    chk("ovr.drop_e6", 32'(overrun), 32'd0);
    repeat (5) @(posedge clock);
    #1;
    chk("ovr.no_done_e11", 32'(done), 32'd0);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("ovr.done_e12", 32'(done), 32'd1);
    chk("ovr.fin_pulse", 32'(overrun), 32'd1);
    chk("ovr.result", 32'(result), 32'(exp_q.pop_front()));
    chk("ovr.busy_e12", 32'(busy), 32'd0);
    @(posedge clock); #1;
    chk("ovr.ignored_busy", 32'(busy), 32'd0);
    chk("ovr.ignored_done", 32'(done), 32'd0);
    chk("ovr.fin_drop", 32'(overrun), 32'd0);

    // back-to-back: ADD 3+4 issued in the done cycle of DIV 1000/7
    issue(4'd3, 10'd1000, 10'd7);
    exp_q.push_back(20'd142);
    wait_done(40, lat);
    chk("b2b.div_lat", lat, 12);
    chk("b2b.div_result", 32'(result), 32'(exp_q.pop_front()));
    num1 = 10'd3; num2 = 10'd4; op = 4'd0; start = 1'b1;
    exp_q.push_back(20'd7);
    @(posedge clock); #1;
    start = 1'b0;
    chk("b2b.accept_busy", 32'(busy), 32'd1);
    chk("b2b.accept_done", 32'(done), 32'd0);
    chk("b2b.no_overrun", 32'(overrun), 32'd0);
    @(posedge clock); #1;
    chk("b2b.add_done", 32'(done), 32'd1);
    chk("b2b.add_result", 32'(result), 32'(exp_q.pop_front()));

    // reset in the middle of a MUL
    @(posedge clock);
    issue(4'd2, 10'd1023, 10'd1023);
    repeat (6) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("mrst.result", 32'(result), 32'd0);
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.done", 32'(done), 32'd0);
    chk("mrst.flags", 32'({err, neg, overrun}), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    stray = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clock); #1;
      if (done || busy) stray++;
    end
    chk("mrst.no_done", stray, 0);
    issue(4'd0, 10'd1, 10'd1);
    exp_q.push_back(20'd2);
    wait_done(5, lat);
    chk("mrst.add_lat", lat, 1);
    chk("mrst.add_result", 32'(result), 32'(exp_q.pop_front()));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
